sram_req_arbiter: RTL and testbench

- Shares one SRAM-like memory port between the instruction-fetch requester and the execute-stage data requester.
- Keeps a request locked until the memory accepts it.
- Tracks up to OUTSTANDING accepted transactions in an in-order ID FIFO and steers each data_ok/rdata back to its originating requester.
- Sits between the pipeline stages and the memory/bridge side of the core.

---
 rtl/sram_req_arbiter_pkg.sv | 17 +
 rtl/sram_req_arbiter_if.sv | 25 ++
 rtl/sram_req_arbiter_chk.sv | 34 +++
 rtl/sram_req_arbiter_id_fifo.sv | 59 +++++
 rtl/sram_req_arbiter.sv | 106 ++++++++++
 tb/tb_sram_req_arbiter.sv | 279 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/sram_req_arbiter_pkg.sv
// Shared constants and types for the instruction/data SRAM request arbiter.
package sram_req_arbiter_pkg;

    localparam logic [1:0] SRAM_SIZE_B = 2'd0;
    localparam logic [1:0] SRAM_SIZE_H = 2'd1;
    localparam logic [1:0] SRAM_SIZE_W = 2'd2;

    localparam logic REQ_ID_INST = 1'b0;
    localparam logic REQ_ID_DATA = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_LOCK_I = 2'd1,
        ARB_LOCK_D = 2'd2
    } arb_state_e;

endpackage

// File: rtl/sram_req_arbiter_if.sv
// SRAM-like request/response port; the master issues requests, the slave answers them.
interface sram_req_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  req;
    logic                  wr;
    logic [1:0]            size;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W/8-1:0]   wstrb;
    logic [DATA_W-1:0]     wdata;
    logic                  addr_ok;
    logic                  data_ok;
    logic [DATA_W-1:0]     rdata;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_req_arbiter_chk.sv
// Protocol checker for the memory side: flags a response with no accepted transaction outstanding.
module sram_req_arbiter_chk (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic mem_req,
    input  logic mem_addr_ok,
    input  logic mem_data_ok,
    output logic proto_err
);
    logic [7:0] shadow_cnt_r;
    logic       acc_s;
    logic       ret_s;

    assign acc_s     = mem_req & mem_addr_ok;
    assign ret_s     = mem_data_ok & (shadow_cnt_r != 8'd0);
    assign proto_err = mem_data_ok & (shadow_cnt_r == 8'd0);

    // Independent count of accepted-but-unanswered transactions seen on the memory port.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_cnt_r <= 8'd0;
        end else begin
            case ({acc_s, ret_s})
                2'b10:   shadow_cnt_r <= shadow_cnt_r + 8'd1;
                2'b01:   shadow_cnt_r <= shadow_cnt_r - 8'd1;
                default: shadow_cnt_r <= shadow_cnt_r;
            endcase
        end
    end

    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (reset || !en) !proto_err);

endmodule

// File: rtl/sram_req_arbiter_id_fifo.sv
// In-order ID FIFO with simultaneous push/pop, including push while full when a pop frees the slot.
module sync_id_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] cnt_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign pop_ok_s  = pop & ~empty;
    assign push_ok_s = push & (~full | pop_ok_s);
    assign full      = (cnt_r == CNT_W'(DEPTH));
    assign empty     = (cnt_r == CNT_W'(0));
    assign head      = mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping; pointers wrap at DEPTH-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            cnt_r    <= CNT_W'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= (wr_ptr_r == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= (rd_ptr_r == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   cnt_r <= cnt_r + CNT_W'(1);
                2'b01:   cnt_r <= cnt_r - CNT_W'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Entry storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and data access, routing responses in order.
module sram_req_arbiter
    import sram_req_arbiter_pkg::*;
#(
    parameter int OUTSTANDING = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic                clk,
    input  logic                reset,
    sram_req_arbiter_if.slave   inst_sram,
    sram_req_arbiter_if.slave   data_sram,
    sram_req_arbiter_if.master  mem
);
    arb_state_e state_r;
    arb_state_e state_next_s;
    logic       grant_data_s;
    logic       sel_req_s;
    logic       mem_req_s;
    logic       push_s;
    logic       pop_s;
    logic       block_s;
    logic       fifo_full_s;
    logic       fifo_empty_s;
    logic       fifo_head_s;

    // A response retiring in the same cycle frees the slot, so a full FIFO only blocks without a pop.
    assign pop_s   = mem.data_ok & ~fifo_empty_s;
    assign block_s = fifo_full_s & ~pop_s;

    // Grant selection: data has priority when idle, a lock pins the grant.
    always_comb begin
        grant_data_s = 1'b0;
        case (state_r)
            ARB_IDLE:   grant_data_s = data_sram.req;
            ARB_LOCK_I: grant_data_s = 1'b0;
            ARB_LOCK_D: grant_data_s = 1'b1;
            default:    grant_data_s = 1'b0;
        endcase
    end

    assign sel_req_s = grant_data_s ? data_sram.req : inst_sram.req;
    assign mem_req_s = sel_req_s & ~block_s;
    assign push_s    = mem_req_s & mem.addr_ok;

    assign mem.req   = mem_req_s;
    assign mem.wr    = grant_data_s ? data_sram.wr    : inst_sram.wr;
    assign mem.size  = grant_data_s ? data_sram.size  : inst_sram.size;
    assign mem.addr  = grant_data_s ? data_sram.addr  : inst_sram.addr;
    assign mem.wstrb = grant_data_s ? data_sram.wstrb : inst_sram.wstrb;
    assign mem.wdata = grant_data_s ? data_sram.wdata : inst_sram.wdata;

    assign inst_sram.addr_ok = push_s & ~grant_data_s;
    assign data_sram.addr_ok = push_s & grant_data_s;

    assign inst_sram.data_ok = pop_s & (fifo_head_s == REQ_ID_INST);
    assign data_sram.data_ok = pop_s & (fifo_head_s == REQ_ID_DATA);
    assign inst_sram.rdata   = mem.rdata;
    assign data_sram.rdata   = mem.rdata;

    // Next-state: lock onto a forwarded but unaccepted request, release on acceptance.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ARB_IDLE: begin
                if (mem_req_s & ~mem.addr_ok) begin
                    state_next_s = grant_data_s ? ARB_LOCK_D : ARB_LOCK_I;
                end else begin
                    state_next_s = ARB_IDLE;
                end
            end
            ARB_LOCK_I, ARB_LOCK_D: begin
                if (push_s) begin
                    state_next_s = ARB_IDLE;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: state_next_s = ARB_IDLE;
        endcase
    end

    // Grant state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ARB_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    sync_id_fifo #(
        .DEPTH (OUTSTANDING),
        .WIDTH (1)
    ) u_id_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (grant_data_s ? REQ_ID_DATA : REQ_ID_INST),
        .pop       (pop_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .head      (fifo_head_s)
    );

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: queued expectations checked by a negedge monitor plus spot checks.
module tb_sram_req_arbiter;

    logic clk = 1'b0;
    logic reset;
    logic chk_en;
    logic proto_err;

    always #5 clk = ~clk;

    sram_req_arbiter_if #(.ADDR_W(32), .DATA_W(32)) inst_if ();
    sram_req_arbiter_if #(.ADDR_W(32), .DATA_W(32)) data_if ();
    sram_req_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

    sram_req_arbiter #(.OUTSTANDING(2), .ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .inst_sram (inst_if),
        .data_sram (data_if),
        .mem       (mem_if)
    );

    sram_req_arbiter_chk u_chk (
        .clk         (clk),
        .reset       (reset),
        .en          (chk_en),
        .mem_req     (mem_if.req),
        .mem_addr_ok (mem_if.addr_ok),
        .mem_data_ok (mem_if.data_ok),
        .proto_err   (proto_err)
    );

    typedef struct {
        bit          is_data;
        logic [31:0] val;
    } exp_t;

    exp_t acc_q[$];
    exp_t rsp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_acc(input bit is_data, input logic [31:0] addr);
        exp_t e;
        e.is_data = is_data;
        e.val     = addr;
        acc_q.push_back(e);
    endtask

    task automatic exp_rsp(input bit is_data, input logic [31:0] rdata);
        exp_t e;
        e.is_data = is_data;
        e.val     = rdata;
        rsp_q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Monitor: every acceptance and every response is matched against the expectation queues.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (mem_if.req && mem_if.addr_ok) begin
                if (acc_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_accept: got addr %h expected no acceptance", mem_if.addr);
                end else begin
                    mon_e = acc_q.pop_front();
                    chk("accept_addr", mem_if.addr, mon_e.val);
                    chk("accept_who", {30'd0, data_if.addr_ok, inst_if.addr_ok}, mon_e.is_data ? 32'd2 : 32'd1);
                end
            end else begin
                chk("no_stray_addr_ok", {30'd0, data_if.addr_ok, inst_if.addr_ok}, 32'd0);
            end
            if (inst_if.data_ok || data_if.data_ok) begin
                if (rsp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_data_ok: got inst %b data %b expected none", inst_if.data_ok, data_if.data_ok);
                end else begin
                    mon_e = rsp_q.pop_front();
                    chk("rsp_who", {30'd0, data_if.data_ok, inst_if.data_ok}, mon_e.is_data ? 32'd2 : 32'd1);
                    chk("rsp_rdata", mon_e.is_data ? data_if.rdata : inst_if.rdata, mon_e.val);
                end
            end
        end
    end

    initial begin
        reset          = 1'b1;
        chk_en         = 1'b1;
        inst_if.req    = 1'b0; inst_if.wr = 1'b0; inst_if.size = 2'd2;
        inst_if.addr   = 32'h0; inst_if.wstrb = 4'hF; inst_if.wdata = 32'h0;
        data_if.req    = 1'b0; data_if.wr = 1'b0; data_if.size = 2'd2;
        data_if.addr   = 32'h0; data_if.wstrb = 4'hF; data_if.wdata = 32'h0;
        mem_if.addr_ok = 1'b0; mem_if.data_ok = 1'b0; mem_if.rdata = 32'h0;

        cyc(); cyc();
        reset = 1'b0;
        settle();
        chk("rst_mem_req", mem_if.req, 32'd0);
        chk("rst_addr_ok", {30'd0, data_if.addr_ok, inst_if.addr_ok}, 32'd0);
        chk("rst_data_ok", {30'd0, data_if.data_ok, inst_if.data_ok}, 32'd0);
        cyc();

        // Both request together: data first, then instruction.
        inst_if.req = 1'b1; inst_if.addr = 32'h1c000000;
        data_if.req = 1'b1; data_if.addr = 32'h00001000;
        mem_if.addr_ok = 1'b1;
        exp_acc(1'b1, 32'h00001000);
        settle();
        chk("t1_c0_mem_addr", mem_if.addr, 32'h00001000);
        chk("t1_c0_data_addr_ok", data_if.addr_ok, 32'd1);
        cyc();
        data_if.req = 1'b0;
        exp_acc(1'b0, 32'h1c000000);
        settle();
        chk("t1_c1_mem_addr", mem_if.addr, 32'h1c000000);
        cyc();
        inst_if.req = 1'b0; mem_if.addr_ok = 1'b0;
        mem_if.data_ok = 1'b1; mem_if.rdata = 32'h000000A1; exp_rsp(1'b1, 32'h000000A1);
        cyc();
        mem_if.rdata = 32'h000000A2; exp_rsp(1'b0, 32'h000000A2);
        cyc();
        mem_if.data_ok = 1'b0;

        // Instruction locks the port while memory stalls; data waits its turn.
        inst_if.req = 1'b1; inst_if.addr = 32'h1c000000;
        settle();
        chk("t2_c0_mem_addr", mem_if.addr, 32'h1c000000);
        chk("t2_c0_inst_addr_ok", inst_if.addr_ok, 32'd0);
        cyc();
        data_if.req = 1'b1; data_if.addr = 32'h00002000;
        settle();
        chk("t2_c1_lock_i", mem_if.addr, 32'h1c000000);
        chk("t2_c1_data_addr_ok", data_if.addr_ok, 32'd0);
        cyc();
        settle();
        chk("t2_c2_lock_i", mem_if.addr, 32'h1c000000);
        cyc();
        mem_if.addr_ok = 1'b1; exp_acc(1'b0, 32'h1c000000);
        cyc();
        inst_if.req = 1'b0; exp_acc(1'b1, 32'h00002000);
        settle();
        chk("t2_c4_mem_addr", mem_if.addr, 32'h00002000);
        cyc();
        data_if.req = 1'b0; mem_if.addr_ok = 1'b0;
        mem_if.data_ok = 1'b1; mem_if.rdata = 32'h000000B1; exp_rsp(1'b0, 32'h000000B1);
        cyc();
        mem_if.rdata = 32'h000000B2; exp_rsp(1'b1, 32'h000000B2);
        cyc();
        mem_if.data_ok = 1'b0;

        // Full FIFO blocks a third request until a response frees a slot in the same cycle.
        inst_if.req = 1'b1; inst_if.addr = 32'h00000100; mem_if.addr_ok = 1'b1;
        exp_acc(1'b0, 32'h00000100);
        cyc();
        inst_if.req = 1'b0; data_if.req = 1'b1; data_if.addr = 32'h00000200;
        exp_acc(1'b1, 32'h00000200);
        cyc();
        data_if.req = 1'b0; inst_if.req = 1'b1; inst_if.addr = 32'h00000300;
        settle();
        chk("t3_full_mem_req_c2", mem_if.req, 32'd0);
        chk("t3_full_inst_addr_ok", inst_if.addr_ok, 32'd0);
        cyc();
        settle();
        chk("t3_full_mem_req_c3", mem_if.req, 32'd0);
        cyc();
        mem_if.data_ok = 1'b1; mem_if.rdata = 32'hDEADBEEF;
        exp_rsp(1'b0, 32'hDEADBEEF);
        exp_acc(1'b0, 32'h00000300);
        settle();
        chk("t3_pushpop_mem_req", mem_if.req, 32'd1);
        chk("t3_inst_data_ok", inst_if.data_ok, 32'd1);
        chk("t3_inst_rdata", inst_if.rdata, 32'hDEADBEEF);
        cyc();
        inst_if.req = 1'b0; mem_if.addr_ok = 1'b0;
        mem_if.rdata = 32'h000000C2; exp_rsp(1'b1, 32'h000000C2);
        cyc();
        mem_if.rdata = 32'h000000C3; exp_rsp(1'b0, 32'h000000C3);
        cyc();
        mem_if.data_ok = 1'b0;

        // In-order routing of D, I, D.
        data_if.req = 1'b1; data_if.addr = 32'h00000400; mem_if.addr_ok = 1'b1;
        exp_acc(1'b1, 32'h00000400);
        cyc();
        data_if.req = 1'b0; inst_if.req = 1'b1; inst_if.addr = 32'h00000500;
        exp_acc(1'b0, 32'h00000500);
        cyc();
        inst_if.req = 1'b0; data_if.req = 1'b1; data_if.addr = 32'h00000600;
        exp_acc(1'b1, 32'h00000600);
        mem_if.data_ok = 1'b1; mem_if.rdata = 32'h00000011; exp_rsp(1'b1, 32'h00000011);
        cyc();
        data_if.req = 1'b0; mem_if.addr_ok = 1'b0;
        mem_if.rdata = 32'h00000022; exp_rsp(1'b0, 32'h00000022);
        cyc();
        mem_if.rdata = 32'h00000033; exp_rsp(1'b1, 32'h00000033);
        cyc();
        mem_if.data_ok = 1'b0;

        // Write payload passes straight through.
        data_if.req = 1'b1; data_if.wr = 1'b1; data_if.size = 2'd0; data_if.wstrb = 4'b0100;
        data_if.wdata = 32'h00AB0000; data_if.addr = 32'h00003000; mem_if.addr_ok = 1'b1;
        exp_acc(1'b1, 32'h00003000);
        settle();
        chk("t5_mem_wr", mem_if.wr, 32'd1);
        chk("t5_mem_size", mem_if.size, 32'd0);
        chk("t5_mem_wstrb", mem_if.wstrb, 32'h4);
        chk("t5_mem_wdata", mem_if.wdata, 32'h00AB0000);
        cyc();
        data_if.req = 1'b0; data_if.wr = 1'b0; data_if.size = 2'd2; data_if.wstrb = 4'hF;
        mem_if.addr_ok = 1'b0;
        mem_if.data_ok = 1'b1; mem_if.rdata = 32'h0; exp_rsp(1'b1, 32'h0);
        cyc();
        mem_if.data_ok = 1'b0;

        // Reset mid-lock with a transaction outstanding.
        inst_if.req = 1'b1; inst_if.addr = 32'h00000700; mem_if.addr_ok = 1'b1;
        exp_acc(1'b0, 32'h00000700);
        cyc();
        inst_if.req = 1'b0; data_if.req = 1'b1; data_if.addr = 32'h00000900; mem_if.addr_ok = 1'b0;
        settle();
        chk("t6_data_forwarded", mem_if.addr, 32'h00000900);
        cyc();
        inst_if.req = 1'b1; inst_if.addr = 32'h00000A00;
        settle();
        chk("t6_lock_d_holds", mem_if.addr, 32'h00000900);
        chk("t6_inst_blocked", inst_if.addr_ok, 32'd0);
        cyc();
        reset = 1'b1; data_if.req = 1'b0;
        cyc();
        reset = 1'b0;
        settle();
        chk("t6_idle_mem_req", mem_if.req, 32'd1);
        chk("t6_idle_mem_addr", mem_if.addr, 32'h00000A00);
        cyc();
        inst_if.req = 1'b0; chk_en = 1'b0;
        mem_if.data_ok = 1'b1; mem_if.rdata = 32'h00000055;
        settle();
        chk("t6_orphan_inst_data_ok", inst_if.data_ok, 32'd0);
        chk("t6_orphan_data_data_ok", data_if.data_ok, 32'd0);
        chk("t6_orphan_flagged", proto_err, 32'd1);
        cyc();
        mem_if.data_ok = 1'b0;
        cyc();
        chk_en = 1'b1;
        inst_if.req = 1'b1; inst_if.addr = 32'h00000A00; mem_if.addr_ok = 1'b1;
        exp_acc(1'b0, 32'h00000A00);
        cyc();
        inst_if.req = 1'b0; mem_if.addr_ok = 1'b0;
        mem_if.data_ok = 1'b1; mem_if.rdata = 32'h00000066; exp_rsp(1'b0, 32'h00000066);
        cyc();
        mem_if.data_ok = 1'b0;
        cyc(); cyc();

        chk("acc_q_drained", acc_q.size(), 32'd0);
        chk("rsp_q_drained", rsp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
